// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail light sequencer: state codes, mode codes,
// the lamp pattern for every state and the lamps a brake press may light.
// Lamp vector order is {LC,LB,LA,RA,RB,RC}: LA (bit 3) and RA (bit 2) are the
// inner lamps, so a sweep grows outward from the centre of the car.
package tail_light_pkg;

    // One code per FSM state. The FSM register itself is plain logic [2:0].
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_R1   = 3'd4,
        ST_R2   = 3'd5,
        ST_R3   = 3'd6,
        ST_HZ   = 3'd7
    } state_e;

    // Encodings presented on active_mode.
    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;
    localparam logic [1:0] MODE_HAZARD = 2'd3;

    // Lamp pattern shown while the FSM sits in each state.
    localparam logic [5:0] PAT_IDLE = 6'b000_000;
    localparam logic [5:0] PAT_L1   = 6'b001_000;
    localparam logic [5:0] PAT_L2   = 6'b011_000;
    localparam logic [5:0] PAT_L3   = 6'b111_000;
    localparam logic [5:0] PAT_R1   = 6'b000_100;
    localparam logic [5:0] PAT_R2   = 6'b000_110;
    localparam logic [5:0] PAT_R3   = 6'b000_111;
    localparam logic [5:0] PAT_HZ   = 6'b111_111;

    // Halves of the lamp vector, used to build the brake override.
    localparam logic [5:0] HALF_LEFT  = 6'b111_000;
    localparam logic [5:0] HALF_RIGHT = 6'b000_111;

    // Lamp pattern for a given state code.
    function automatic logic [5:0] state_pattern(input logic [2:0] s);
        logic [5:0] pat;
        pat = PAT_IDLE;
        case (s)
            ST_IDLE: pat = PAT_IDLE;
            ST_L1:   pat = PAT_L1;
            ST_L2:   pat = PAT_L2;
            ST_L3:   pat = PAT_L3;
            ST_R1:   pat = PAT_R1;
            ST_R2:   pat = PAT_R2;
            ST_R3:   pat = PAT_R3;
            ST_HZ:   pat = PAT_HZ;
            default: pat = PAT_IDLE;
        endcase
        return pat;
    endfunction

    // Mode code reported for a given state code.
    function automatic logic [1:0] state_mode(input logic [2:0] s);
        logic [1:0] mode;
        mode = MODE_IDLE;
        case (s)
            ST_L1, ST_L2, ST_L3: mode = MODE_LEFT;
            ST_R1, ST_R2, ST_R3: mode = MODE_RIGHT;
            ST_HZ:               mode = MODE_HAZARD;
            default:             mode = MODE_IDLE;
        endcase
        return mode;
    endfunction

    // Lamps the brake may force on: every half not owned by a sweep.
    // Hazard owns both halves, so the brake adds nothing there.
    function automatic logic [5:0] brake_mask(input logic [2:0] s);
        logic [5:0] mask;
        mask = 6'b000_000;
        case (s)
            ST_IDLE:             mask = HALF_LEFT | HALF_RIGHT;
            ST_L1, ST_L2, ST_L3: mask = HALF_RIGHT;
            ST_R1, ST_R2, ST_R3: mask = HALF_LEFT;
            ST_HZ:               mask = 6'b000_000;
            default:             mask = 6'b000_000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tail_light_sequencer_prescaler.sv
// Animation prescaler for the tail light sequencer (module tick_prescaler).
// Counts 0..DIV-1 and wraps; tick is high combinationally on the last count.
// With DIV=1 the counter is held at 0 and tick is permanently high.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    import tail_light_pkg::*;

    // A one-bit counter is kept even for DIV=1 so the logic stays uniform.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Last count of the period marks an animation step.
    always_comb begin
        tick = (cnt == LAST);
    end

    // Free-running divider, restarted from 0 by reset and on every wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail light sequencer top level: arbitrates left/right/hazard requests,
// steps the 8-state lamp FSM once per prescaler tick and drives the six lamps.
// Optional feature: define BRAKE_EN to let the brake pedal light every lamp
// half that is not owned by a running sweep. Without it the brake is ignored.
module tail_light_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake,
    output logic [5:0] light_out,
    output logic [1:0] active_mode,
    output logic       step_tick
);
    import tail_light_pkg::*;

    // State codes used by the FSM register.
    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_L1   = ST_L1;
    localparam logic [2:0] S_L2   = ST_L2;
    localparam logic [2:0] S_L3   = ST_L3;
    localparam logic [2:0] S_R1   = ST_R1;
    localparam logic [2:0] S_R2   = ST_R2;
    localparam logic [2:0] S_R3   = ST_R3;
    localparam logic [2:0] S_HZ   = ST_HZ;

    logic       tick;
    logic [2:0] state;
    logic [2:0] next_state;
    logic [5:0] next_light;
    logic [1:0] next_mode;
    logic       both_turns;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Both turn switches at once is treated exactly like a hazard request.
    always_comb begin
        both_turns = left_req & right_req;
    end

    // Next-state logic: arbitration happens only in IDLE, sweeps run to the
    // end unless hazard preempts them, and nothing moves between ticks.
    always_comb begin
        next_state = state;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (hazard_req || both_turns) begin
                        next_state = S_HZ;
                    end else if (left_req) begin
                        next_state = S_L1;
                    end else if (right_req) begin
                        next_state = S_R1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
                S_L1:    next_state = hazard_req ? S_HZ : S_L2;
                S_L2:    next_state = hazard_req ? S_HZ : S_L3;
                S_L3:    next_state = hazard_req ? S_HZ : S_IDLE;
                S_R1:    next_state = hazard_req ? S_HZ : S_R2;
                S_R2:    next_state = hazard_req ? S_HZ : S_R3;
                S_R3:    next_state = hazard_req ? S_HZ : S_IDLE;
                S_HZ:    next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

`ifdef BRAKE_EN
    // Lamp decode from the next state, with the brake filling any half that
    // no sweep owns; evaluated every cycle so the brake acts without a tick.
    always_comb begin
        next_light = state_pattern(next_state);
        if (brake) begin
            next_light = next_light | brake_mask(next_state);
        end
    end
`else
    logic brake_unused;

    // Brake has no effect in this build; it is kept only as a port.
    always_comb begin
        brake_unused = brake;
    end

    // Lamp decode from the next state so lamps change on the state edge.
    always_comb begin
        next_light = state_pattern(next_state);
    end
`endif

    // Mode follows the state the FSM is about to enter.
    always_comb begin
        next_mode = state_mode(next_state);
    end

    // State, lamp and mode registers plus the registered copy of tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            light_out   <= 6'b000_000;
            active_mode <= MODE_IDLE;
            step_tick   <= 1'b0;
        end else begin
            state       <= next_state;
            light_out   <= next_light;
            active_mode <= next_mode;
            step_tick   <= tick;
        end
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench for tail_light_sequencer with TICK_DIV=4.
// A behavioural model (phase counter, mode and sweep length) predicts the
// outputs every cycle; directed scenarios add hand-computed lamp patterns,
// then randomized requests, brake and resets run against the model.
module tb_tail_light_sequencer;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic       left_req;
    logic       right_req;
    logic       hazard_req;
    logic       brake;
    logic [5:0] light_out;
    logic [1:0] active_mode;
    logic       step_tick;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit         m_valid = 0;
    int         m_phase = 0;
    int         m_mode  = 0;
    int         m_len   = 0;
    bit         m_tick  = 0;
    logic [5:0] m_light = '0;

    tail_light_sequencer #(
        .TICK_DIV (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .left_req    (left_req),
        .right_req   (right_req),
        .hazard_req  (hazard_req),
        .brake       (brake),
        .light_out   (light_out),
        .active_mode (active_mode),
        .step_tick   (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamps lit for a mode (0 idle, 1 left, 2 right, 3 hazard) and sweep length.
    function automatic logic [5:0] model_lamps(input int mode, input int len, input bit brk);
        int left_half;
        int right_half;
        left_half  = 0;
        right_half = 0;
        if (mode == 1) left_half = (1 << len) - 1;
        if (mode == 2) right_half = (7 << (3 - len)) & 7;
        if (mode == 3) begin
            left_half  = 7;
            right_half = 7;
        end
`ifdef BRAKE_EN
        if (brk && mode != 3) begin
            if (mode != 1) left_half = 7;
            if (mode != 2) right_half = 7;
        end
`else
        if (brk) begin
            left_half = left_half;
        end
`endif
        return 6'((left_half << 3) | right_half);
    endfunction

    // Reference model: advances on every rising edge from the sampled inputs.
    always @(posedge clk) begin
        bit tk;
        if (reset) begin
            m_valid = 1;
            m_phase = 0;
            m_mode  = 0;
            m_len   = 0;
            m_tick  = 0;
            m_light = '0;
        end else if (m_valid) begin
            tk      = (m_phase == DIV - 1);
            m_tick  = tk;
            m_phase = tk ? 0 : m_phase + 1;
            if (tk) begin
                if (m_mode == 0) begin
                    if (hazard_req || (left_req && right_req)) begin
                        m_mode = 3;
                    end else if (left_req) begin
                        m_mode = 1;
                        m_len  = 1;
                    end else if (right_req) begin
                        m_mode = 2;
                        m_len  = 1;
                    end
                end else if (m_mode == 3) begin
                    m_mode = 0;
                end else if (hazard_req) begin
                    m_mode = 3;
                end else if (m_len == 3) begin
                    m_mode = 0;
                end else begin
                    m_len = m_len + 1;
                end
            end
            m_light = model_lamps(m_mode, m_len, brake);
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checks = checks + 3;
            if (light_out !== m_light) begin
                errors = errors + 1;
                $display("[TB] FAIL model_light t=%0t: got %b expected %b", $time, light_out, m_light);
            end
            if (active_mode !== 2'(m_mode)) begin
                errors = errors + 1;
                $display("[TB] FAIL model_mode t=%0t: got %0d expected %0d", $time, active_mode, m_mode);
            end
            if (step_tick !== m_tick) begin
                errors = errors + 1;
                $display("[TB] FAIL model_tick t=%0t: got %b expected %b", $time, step_tick, m_tick);
            end
        end
    end

    task automatic applyStimulus(input bit l, input bit r, input bit h, input bit b);
        left_req   = l;
        right_req  = r;
        hazard_req = h;
        brake      = b;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        reset = 1'b1;
        waitEdges(2);
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp_light,
                               input logic [1:0] exp_mode, input logic exp_tick);
        checks = checks + 1;
        if (light_out !== exp_light || active_mode !== exp_mode || step_tick !== exp_tick) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got light=%b mode=%0d tick=%b expected light=%b mode=%0d tick=%b",
                     name, light_out, active_mode, step_tick, exp_light, exp_mode, exp_tick);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);

        // Left request held: sweep repeats with a 16-cycle period.
        doReset();
        checkOutput("reset_values", 6'b000000, 2'd0, 1'b0);
        applyStimulus(1, 0, 0, 0);
        waitEdges(3);
        checkOutput("before_first_tick", 6'b000000, 2'd0, 1'b0);
        waitEdges(1);
        checkOutput("left_l1", 6'b001000, 2'd1, 1'b1);
        waitEdges(1);
        checkOutput("left_l1_hold", 6'b001000, 2'd1, 1'b0);
        waitEdges(3);
        checkOutput("left_l2", 6'b011000, 2'd1, 1'b1);
        waitEdges(4);
        checkOutput("left_l3", 6'b111000, 2'd1, 1'b1);
        waitEdges(4);
        checkOutput("left_idle", 6'b000000, 2'd0, 1'b1);
        waitEdges(4);
        checkOutput("left_l1_again", 6'b001000, 2'd1, 1'b1);

        // Right pulse that misses the tick edge is lost.
        doReset();
        waitEdges(1);
        applyStimulus(0, 1, 0, 0);
        waitEdges(1);
        applyStimulus(0, 0, 0, 0);
        waitEdges(2);
        checkOutput("right_pulse_lost", 6'b000000, 2'd0, 1'b1);

        // Both turns together blink as hazard.
        doReset();
        applyStimulus(1, 1, 0, 0);
        waitEdges(4);
        checkOutput("both_hz_on", 6'b111111, 2'd3, 1'b1);
        waitEdges(4);
        checkOutput("both_hz_off", 6'b000000, 2'd0, 1'b1);
        waitEdges(4);
        checkOutput("both_hz_on2", 6'b111111, 2'd3, 1'b1);

        // Hazard preempts a left sweep at the next tick only.
        doReset();
        applyStimulus(1, 0, 0, 0);
        waitEdges(4);
        checkOutput("pre_l1", 6'b001000, 2'd1, 1'b1);
        applyStimulus(0, 0, 1, 0);
        waitEdges(2);
        checkOutput("pre_wait", 6'b001000, 2'd1, 1'b0);
        waitEdges(2);
        checkOutput("pre_hz", 6'b111111, 2'd3, 1'b1);
        applyStimulus(0, 0, 0, 0);
        waitEdges(4);
        checkOutput("pre_idle", 6'b000000, 2'd0, 1'b1);

        // Dropped left request still finishes the sweep.
        doReset();
        applyStimulus(1, 0, 0, 0);
        waitEdges(4);
        applyStimulus(0, 0, 0, 0);
        waitEdges(4);
        checkOutput("drop_l2", 6'b011000, 2'd1, 1'b1);
        waitEdges(4);
        checkOutput("drop_l3", 6'b111000, 2'd1, 1'b1);
        waitEdges(4);
        checkOutput("drop_idle", 6'b000000, 2'd0, 1'b1);

        // Reset in the middle of a right sweep.
        doReset();
        applyStimulus(0, 1, 0, 0);
        waitEdges(4);
        checkOutput("r_r1", 6'b000100, 2'd2, 1'b1);
        applyStimulus(0, 0, 0, 0);
        waitEdges(4);
        checkOutput("r_r2", 6'b000110, 2'd2, 1'b1);
        waitEdges(1);
        reset = 1'b1;
        waitEdges(1);
        checkOutput("r_mid_reset", 6'b000000, 2'd0, 1'b0);
        reset = 1'b0;
        applyStimulus(0, 1, 0, 0);
        waitEdges(3);
        checkOutput("r_restart_wait", 6'b000000, 2'd0, 1'b0);
        waitEdges(1);
        checkOutput("r_restart_r1", 6'b000100, 2'd2, 1'b1);

        // Brake behaviour depends on the build.
        doReset();
        applyStimulus(0, 0, 0, 1);
        waitEdges(1);
`ifdef BRAKE_EN
        checkOutput("brake_idle", 6'b111111, 2'd0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        waitEdges(3);
        checkOutput("brake_l1", 6'b001111, 2'd1, 1'b1);
        waitEdges(4);
        checkOutput("brake_l2", 6'b011111, 2'd1, 1'b1);
        waitEdges(4);
        checkOutput("brake_l3", 6'b111111, 2'd1, 1'b1);
`else
        checkOutput("brake_ignored", 6'b000000, 2'd0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        waitEdges(3);
        checkOutput("brake_ignored_l1", 6'b001000, 2'd1, 1'b1);
`endif

        // Randomized requests, brake and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        waitEdges(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
